multimode_register_bank: RTL and testbench
==========================================

Name: multimode_register_bank

Overview:
- Parametrised successor to the single 8-bit mode register unit.
- Holds DEPTH registers of WIDTH bits, addressed per command.
- Executes shift/rotate, Gray up/down count, invert, half-swap and load operations under a valid/ready command handshake.
- Adds multi-bit rotates, executed one bit per cycle, and a Gray-to-binary load.
- The selected result is presented on a shared tri-state io_bus.

Parameters:
- WIDTH, 8, register and bus width; must be even and >= 4.
- ADDR_W, 2, register address width; DEPTH = 2**ADDR_W registers.
- AMT_W, 3, rotate-amount width; must be >= $clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- io_bus  inout  WIDTH  shared data bus; driven with out_reg when output_control=1, else high-Z.
- output_control  input  1  1 = block drives io_bus; 0 = bus is an input.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- mode_input  input  4  operation code.
- addr  input  ADDR_W  target register.
- amount  input  AMT_W  rotate amount; ignored for other modes.
- done  output  1  one-cycle pulse when a command completes.
- err  output  1  one-cycle pulse, coincident with done, when a command is rejected.
- zero  output  1  high when out_reg == 0.

Behaviour:
- Reset (synchronous, active-high) clears:
  - all DEPTH registers, out_reg, done, err and the rotate counter;
  - FSM goes to IDLE; cmd_ready=1 in the first cycle after reset; zero=1.
- Reset asserted mid-rotate aborts the command and clears the target register (all registers clear). No done pulse is issued.
- Handshake: a command is accepted at a rising edge with cmd_valid & cmd_ready. mode_input, addr and amount are sampled only at acceptance.
- cmd_ready = (state == IDLE).
- FSM states: IDLE, ROT.
- Single-cycle modes are executed at the acceptance edge N.
  - reg[addr] and out_reg are updated at edge N.
  - done=1 for the cycle after edge N.
  - FSM stays in IDLE, so back-to-back commands are accepted every cycle.
- Modes:
  - 0 hold: no write; out_reg <= reg[addr].
  - 1 rotate right by amount (multi-cycle).
  - 2 rotate left by amount (multi-cycle).
  - 3 Gray up: reg <= reg+1, mod 2**WIDTH; out_reg <= reg_new ^ (reg_new >> 1).
  - 4 Gray down: reg <= reg-1, mod 2**WIDTH; out_reg = Gray of the new value.
  - 5 invert: reg <= ~reg; out_reg <= new reg.
  - 6 half swap: reg <= {reg[WIDTH/2-1:0], reg[WIDTH-1:WIDTH/2]}; out_reg <= new reg.
  - 7 parallel load: reg <= io_bus; out_reg <= io_bus.
  - 8 Gray load: io_bus is treated as Gray code; reg <= binary equivalent (b[i] = XOR of g[WIDTH-1:i]); out_reg <= binary value.
  - 9-15 reserved: no write, out_reg unchanged, done=1 and err=1.
- Modes 7 and 8 with output_control=1 (bus conflict): rejected; no write; done=1 and err=1.
- Rotate (modes 1/2) with amount k:
  - k == 0: single-cycle; no change; out_reg <= reg[addr].
  - k > 0: at acceptance the FSM enters ROT with counter=k and latches addr and direction.
  - Each ROT cycle rotates reg[addr] by one bit, copies the result to out_reg and decrements the counter.
  - After the edge that performs rotation k, the FSM returns to IDLE and done pulses that same cycle. Total latency is k cycles after acceptance.
  - Rotation is modulo WIDTH: k >= WIDTH is still performed bit-serially, net effect k mod WIDTH.
- Wrap-around: Gray up from all-ones gives binary 0, out_reg=0. Gray down from 0 gives all-ones, out_reg = 1 followed by WIDTH-1 zeros.
- io_bus is driven combinationally from out_reg whenever output_control=1, including during ROT (intermediate values are visible).
- zero is a registered flag of out_reg == 0, updated whenever out_reg changes.

Test Plan:
- Reset, then mode 0 addr 2 with output_control=1 -> io_bus=8'h00, zero=1, done one cycle after accept.
- Load 8'hA5 to addr 1 (output_control=0), then rotate right amount 3 -> cmd_ready low 3 cycles, out_reg steps D2, 69, B4, done on third; retry with output_control=1 -> err=1, reg unchanged.
- Load 8'hFF to addr 0, Gray up -> reg=00, out=00, zero=1; then Gray down twice -> reg=FE, out=8'h81.
- Gray load io_bus=8'hC0 (gray) to addr 3 -> reg=8'h80; invert -> 7F; half swap -> F7.
- Reserved mode 4'hB -> done=1, err=1, no register change.
- Reset asserted during a 5-step rotate at step 2 -> no done, all registers 0, cmd_ready=1 next cycle; back-to-back Gray up commands afterwards accepted every cycle.

Source files
------------

// File: rtl/multimode_register_bank_if.sv
// Command handshake and status interface for multimode_register_bank.
interface multimode_register_bank_if #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned AMT_W  = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        mode_input;
    logic [ADDR_W-1:0] addr;
    logic [AMT_W-1:0]  amount;
    logic              done;
    logic              err;
    logic              zero;

    modport master (
        output cmd_valid, mode_input, addr, amount,
        input  cmd_ready, done, err, zero
    );

    modport slave (
        input  cmd_valid, mode_input, addr, amount,
        output cmd_ready, done, err, zero
    );
endinterface

// File: rtl/multimode_register_bank.sv
// Bank of DEPTH registers with shift/rotate, Gray count, invert, swap and load
// operations; the selected result is shown on a shared tri-state bus.
module multimode_register_bank #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned AMT_W  = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    inout  wire  [WIDTH-1:0]          io_bus,
    input  logic                      output_control,
    multimode_register_bank_if.slave  cmd
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {S_IDLE, S_ROT} state_t;

    state_t            r_state, w_state_nxt;
    logic [WIDTH-1:0]  r_regs [DEPTH];
    logic [WIDTH-1:0]  r_out;
    logic              r_done, r_err, r_zero;
    logic [AMT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] r_rot_addr, w_rot_addr_nxt;
    logic              r_rot_left, w_rot_left_nxt;

    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [WIDTH-1:0]  w_wr_data;
    logic              w_out_ld;
    logic [WIDTH-1:0]  w_out_nxt;
    logic              w_done, w_err;
    logic [WIDTH-1:0]  w_cur, w_rot_cur, w_inc, w_dec;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] rot1(input logic [WIDTH-1:0] x, input logic left);
        return left ? {x[WIDTH-2:0], x[WIDTH-1]} : {x[0], x[WIDTH-1:1]};
    endfunction

    assign w_cur     = r_regs[cmd.addr];
    assign w_rot_cur = r_regs[r_rot_addr];
    assign w_inc     = w_cur + WIDTH'(1);
    assign w_dec     = w_cur - WIDTH'(1);

    assign io_bus        = output_control ? r_out : {WIDTH{1'bz}};
    assign cmd.cmd_ready = (r_state == S_IDLE);
    assign cmd.done      = r_done;
    assign cmd.err       = r_err;
    assign cmd.zero      = r_zero;

    // Next-state, register write and output selection
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_rot_addr_nxt = r_rot_addr;
        w_rot_left_nxt = r_rot_left;
        w_wr_en        = 1'b0;
        w_wr_addr      = cmd.addr;
        w_wr_data      = w_cur;
        w_out_ld       = 1'b0;
        w_out_nxt      = r_out;
        w_done         = 1'b0;
        w_err          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd.cmd_valid) begin
                    w_done = 1'b1;
                    case (cmd.mode_input)
                        4'd0: begin
                            w_out_ld  = 1'b1;
                            w_out_nxt = w_cur;
                        end
                        4'd1, 4'd2: begin
                            if (cmd.amount == '0) begin
                                w_out_ld  = 1'b1;
                                w_out_nxt = w_cur;
                            end else begin
                                w_done         = 1'b0;
                                w_state_nxt    = S_ROT;
                                w_cnt_nxt      = cmd.amount;
                                w_rot_addr_nxt = cmd.addr;
                                w_rot_left_nxt = (cmd.mode_input == 4'd2);
                            end
                        end
                        4'd3: begin
                            w_wr_en   = 1'b1;
                            w_wr_data = w_inc;
                            w_out_ld  = 1'b1;
                            w_out_nxt = bin2gray(w_inc);
                        end
                        4'd4: begin
                            w_wr_en   = 1'b1;
                            w_wr_data = w_dec;
                            w_out_ld  = 1'b1;
                            w_out_nxt = bin2gray(w_dec);
                        end
                        4'd5: begin
                            w_wr_en   = 1'b1;
                            w_wr_data = ~w_cur;
                            w_out_ld  = 1'b1;
                            w_out_nxt = ~w_cur;
                        end
                        4'd6: begin
                            w_wr_en   = 1'b1;
                            w_wr_data = {w_cur[WIDTH/2-1:0], w_cur[WIDTH-1:WIDTH/2]};
                            w_out_ld  = 1'b1;
                            w_out_nxt = {w_cur[WIDTH/2-1:0], w_cur[WIDTH-1:WIDTH/2]};
                        end
                        4'd7, 4'd8: begin
                            // Loading while we drive the bus would read our own value back
                            if (output_control) begin
                                w_err = 1'b1;
                            end else begin
                                w_wr_en   = 1'b1;
                                w_wr_data = (cmd.mode_input == 4'd8) ? gray2bin(io_bus) : io_bus;
                                w_out_ld  = 1'b1;
                                w_out_nxt = w_wr_data;
                            end
                        end
                        default: w_err = 1'b1;
                    endcase
                end
            end
            S_ROT: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_rot_addr;
                w_wr_data = rot1(w_rot_cur, r_rot_left);
                w_out_ld  = 1'b1;
                w_out_nxt = w_wr_data;
                w_cnt_nxt = r_cnt - AMT_W'(1);
                if (r_cnt == AMT_W'(1)) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Datapath registers; zero tracks the value being loaded into out_reg
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) r_regs[i] <= '0;
            r_out      <= '0;
            r_zero     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_rot_addr <= '0;
            r_rot_left <= 1'b0;
        end else begin
            if (w_wr_en) r_regs[w_wr_addr] <= w_wr_data;
            if (w_out_ld) begin
                r_out  <= w_out_nxt;
                r_zero <= (w_out_nxt == '0);
            end
            r_done     <= w_done;
            r_err      <= w_err;
            r_cnt      <= w_cnt_nxt;
            r_rot_addr <= w_rot_addr_nxt;
            r_rot_left <= w_rot_left_nxt;
        end
    end
endmodule

// File: tb/tb_multimode_register_bank.sv
// Directed testbench for multimode_register_bank with hand-computed expectations.
module tb_multimode_register_bank;
    logic       clk = 1'b0;
    logic       reset;
    logic       tb_oc;
    logic [7:0] tb_drv;
    wire  [7:0] io_bus;
    int         total = 0;
    int         bad = 0;

    multimode_register_bank_if #(.ADDR_W(2), .AMT_W(3)) bus ();

    multimode_register_bank #(.WIDTH(8), .ADDR_W(2), .AMT_W(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .io_bus         (io_bus),
        .output_control (tb_oc),
        .cmd            (bus)
    );

    assign io_bus = tb_oc ? 8'hzz : tb_drv;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] m, input logic [1:0] a, input logic [2:0] k);
        bus.cmd_valid  = 1'b1;
        bus.mode_input = m;
        bus.addr       = a;
        bus.amount     = k;
        tick();
        bus.cmd_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", bus.cmd_ready); end
        total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL rst_zero got=%b want=1", bus.zero); end
        total++; if (bus.done !== 1'b0 || bus.err !== 1'b0) begin bad++; $display("FAIL rst_done_err got=%b%b want=00", bus.done, bus.err); end
        tb_oc = 1'b1;
        send(4'd0, 2'd2, 3'd0);
        total++; if (io_bus !== 8'h00) begin bad++; $display("FAIL hold_bus got=%h want=00", io_bus); end
        total++; if (bus.done !== 1'b1 || bus.err !== 1'b0) begin bad++; $display("FAIL hold_done got=%b%b want=10", bus.done, bus.err); end
        total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL hold_zero got=%b want=1", bus.zero); end
        tick();
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL done_pulse got=%b want=0", bus.done); end
    endtask

    task automatic test_rotate();
        logic [7:0] exp_steps [3];
        exp_steps[0] = 8'hD2;
        exp_steps[1] = 8'h69;
        exp_steps[2] = 8'hB4;
        tb_oc  = 1'b0;
        tb_drv = 8'hA5;
        send(4'd7, 2'd1, 3'd0);
        total++; if (bus.done !== 1'b1 || bus.err !== 1'b0) begin bad++; $display("FAIL load_done got=%b%b want=10", bus.done, bus.err); end
        tb_oc = 1'b1;
        #1;
        total++; if (io_bus !== 8'hA5) begin bad++; $display("FAIL load_bus got=%h want=a5", io_bus); end
        send(4'd1, 2'd1, 3'd3);
        total++; if (bus.cmd_ready !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL rot_accept ready/done got=%b%b want=00", bus.cmd_ready, bus.done); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (io_bus !== exp_steps[i]) begin bad++; $display("FAIL rot_step%0d got=%h want=%h", i, io_bus, exp_steps[i]); end
            total++; if (bus.done !== (i == 2)) begin bad++; $display("FAIL rot_done%0d got=%b want=%b", i, bus.done, (i == 2)); end
            total++; if (bus.cmd_ready !== (i == 2)) begin bad++; $display("FAIL rot_ready%0d got=%b want=%b", i, bus.cmd_ready, (i == 2)); end
        end
        tb_drv = 8'h11;
        send(4'd7, 2'd1, 3'd0);
        total++; if (bus.done !== 1'b1 || bus.err !== 1'b1) begin bad++; $display("FAIL conflict_err got=%b%b want=11", bus.done, bus.err); end
        send(4'd0, 2'd1, 3'd0);
        total++; if (io_bus !== 8'hB4 || bus.err !== 1'b0) begin bad++; $display("FAIL conflict_keep got=%h/%b want=b4/0", io_bus, bus.err); end
    endtask

    task automatic test_gray();
        tb_oc  = 1'b0;
        tb_drv = 8'hFF;
        send(4'd7, 2'd0, 3'd0);
        tb_oc = 1'b1;
        send(4'd3, 2'd0, 3'd0);
        total++; if (io_bus !== 8'h00 || bus.zero !== 1'b1) begin bad++; $display("FAIL gray_up_wrap got=%h/%b want=00/1", io_bus, bus.zero); end
        send(4'd4, 2'd0, 3'd0);
        total++; if (io_bus !== 8'h80 || bus.zero !== 1'b0) begin bad++; $display("FAIL gray_dn_wrap got=%h/%b want=80/0", io_bus, bus.zero); end
        send(4'd4, 2'd0, 3'd0);
        total++; if (io_bus !== 8'h81) begin bad++; $display("FAIL gray_dn2 got=%h want=81", io_bus); end
        send(4'd0, 2'd0, 3'd0);
        total++; if (io_bus !== 8'hFE) begin bad++; $display("FAIL gray_reg got=%h want=fe", io_bus); end
    endtask

    task automatic test_gray_load_ops();
        tb_oc  = 1'b0;
        tb_drv = 8'hC0;
        send(4'd8, 2'd3, 3'd0);
        tb_oc = 1'b1;
        #1;
        total++; if (io_bus !== 8'h80) begin bad++; $display("FAIL gray_load got=%h want=80", io_bus); end
        send(4'd5, 2'd3, 3'd0);
        total++; if (io_bus !== 8'h7F) begin bad++; $display("FAIL invert got=%h want=7f", io_bus); end
        send(4'd6, 2'd3, 3'd0);
        total++; if (io_bus !== 8'hF7) begin bad++; $display("FAIL half_swap got=%h want=f7", io_bus); end
        send(4'd2, 2'd3, 3'd0);
        total++; if (io_bus !== 8'hF7 || bus.done !== 1'b1 || bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rot_zero got=%h/%b%b want=f7/11", io_bus, bus.done, bus.cmd_ready); end
        send(4'd2, 2'd3, 3'd1);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rol1_accept got=%b want=0", bus.done); end
        tick();
        total++; if (io_bus !== 8'hEF || bus.done !== 1'b1) begin bad++; $display("FAIL rol1 got=%h/%b want=ef/1", io_bus, bus.done); end
    endtask

    task automatic test_reserved();
        send(4'hB, 2'd3, 3'd0);
        total++; if (bus.done !== 1'b1 || bus.err !== 1'b1) begin bad++; $display("FAIL reserved_err got=%b%b want=11", bus.done, bus.err); end
        total++; if (io_bus !== 8'hEF) begin bad++; $display("FAIL reserved_out got=%h want=ef", io_bus); end
        send(4'd0, 2'd3, 3'd0);
        total++; if (io_bus !== 8'hEF) begin bad++; $display("FAIL reserved_reg got=%h want=ef", io_bus); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_gray [3];
        exp_gray[0] = 8'h01;
        exp_gray[1] = 8'h03;
        exp_gray[2] = 8'h02;
        tb_oc  = 1'b0;
        tb_drv = 8'h3C;
        send(4'd7, 2'd2, 3'd0);
        tb_oc = 1'b1;
        send(4'd1, 2'd2, 3'd5);
        tick();
        total++; if (io_bus !== 8'h1E) begin bad++; $display("FAIL mid_rot_step1 got=%h want=1e", io_bus); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_rst done/ready got=%b%b want=01", bus.done, bus.cmd_ready); end
        total++; if (io_bus !== 8'h00 || bus.zero !== 1'b1) begin bad++; $display("FAIL mid_rst_out got=%h/%b want=00/1", io_bus, bus.zero); end
        tick();
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL mid_rst_late_done got=%b want=0", bus.done); end
        for (int a = 0; a < 4; a++) begin
            send(4'd0, 2'(a), 3'd0);
            total++; if (io_bus !== 8'h00) begin bad++; $display("FAIL mid_rst_reg%0d got=%h want=00", a, io_bus); end
        end
        bus.cmd_valid  = 1'b1;
        bus.mode_input = 4'd3;
        bus.addr       = 2'd0;
        bus.amount     = 3'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (io_bus !== exp_gray[i] || bus.done !== 1'b1 || bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b%0d got=%h/%b%b want=%h/11", i, io_bus, bus.done, bus.cmd_ready, exp_gray[i]); end
        end
        bus.cmd_valid = 1'b0;
        tick();
        total++; if (bus.done !== 1'b0 || io_bus !== 8'h02) begin bad++; $display("FAIL b2b_end got=%h/%b want=02/0", io_bus, bus.done); end
    endtask

    initial begin
        reset          = 1'b1;
        tb_oc          = 1'b1;
        tb_drv         = 8'h00;
        bus.cmd_valid  = 1'b0;
        bus.mode_input = 4'd0;
        bus.addr       = 2'd0;
        bus.amount     = 3'd0;
        test_reset();
        test_rotate();
        test_gray();
        test_gray_load_ops();
        test_reserved();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
